// File: rtl/mips_abb_pkg.sv
// Shared types and constants for the MIPS fetch/decode boundary.
// Holds instruction address/data types, the bubble encoding and the IF FSM states.
package mips_abb_pkg;

    typedef logic [31:0] instr_addr;
    typedef logic [31:0] instr_data;

    localparam instr_data NONE  = 32'h0000_0000;
    localparam instr_addr RESET = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } if_state_e;

    // Branch wins over register jump, which wins over absolute jump.
    function automatic instr_addr redirect_target(
        input logic [2:0] jsel,
        input instr_addr  branch_addr,
        input instr_addr  jc_addr,
        input instr_addr  j_addr
    );
        instr_addr tgt;
        if (jsel[0]) begin
            tgt = branch_addr;
        end else if (jsel[1]) begin
            tgt = jc_addr;
        end else begin
            tgt = j_addr;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc/instruction holding register used when ID stalls on an arriving word.
// Load has priority over unload; the two are never requested together by the fetch FSM.
module if_skid_buf
    import mips_abb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      load_i,
    input  logic      unload_i,
    input  instr_addr pc_i,
    input  instr_data instr_i,
    output logic      valid_o,
    output instr_addr pc_o,
    output instr_data instr_o
);

    logic      valid_q, valid_d;
    instr_addr pc_q, pc_d;
    instr_data instr_q, instr_d;

    // Next-state selection for the single buffer entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= NONE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: drives the iram handshake, tracks redirects with a
// MIPS delay slot, and feeds the IF/ID register, using a skid buffer on ID stalls.
module stage_if
    import mips_abb_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        id_stop,
    input  logic [2:0]  jsel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] j_addr,
    input  logic [31:0] jc_addr,
    output logic        iram_req,
    output logic [31:0] iram_addr,
    input  logic        iram_ack,
    input  logic [31:0] iram_rdata,
    output logic [31:0] if_o_pc,
    output logic [31:0] if_o_pc_4,
    output logic [31:0] if_o_instr
);

    if_state_e state_q, state_d;
    instr_addr fetch_pc_q, fetch_pc_d;
    logic      pend_q, pend_d;
    instr_addr pend_tgt_q, pend_tgt_d;
    instr_addr id_pc_q, id_pc_d;
    instr_addr id_pc4_q, id_pc4_d;
    instr_data id_instr_q, id_instr_d;
    logic      iram_req_q;
    instr_addr iram_addr_q;

    logic      resolve_s;
    instr_addr target_s;
    logic      skid_load_s, skid_unload_s, skid_valid_s;
    instr_addr skid_pc_s;
    instr_data skid_instr_s;

    // A bubble in ID carries no jump, so it can never resolve a redirect.
    assign resolve_s = !id_stop && (jsel != 3'b000) && (id_instr_q != NONE);
    assign target_s  = redirect_target(jsel, branch_addr, jc_addr, j_addr);

    // Fetch FSM, fetch PC, pending redirect and IF/ID next-state logic.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        id_instr_d    = id_instr_q;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (iram_ack) begin
                    // The accepted word is the delay slot when a redirect is known.
                    if (pend_q) begin
                        fetch_pc_d = pend_tgt_q;
                        pend_d     = 1'b0;
                    end else if (resolve_s) begin
                        fetch_pc_d = target_s;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    if (!id_stop) begin
                        id_pc_d    = fetch_pc_q;
                        id_pc4_d   = fetch_pc_q + 32'd4;
                        id_instr_d = iram_rdata;
                    end else begin
                        skid_load_s = 1'b1;
                        state_d     = S_FULL;
                    end
                end else begin
                    if (resolve_s) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = target_s;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (!id_stop) begin
                        id_instr_d = NONE;
                    end else begin
                        id_instr_d = id_instr_q;
                    end
                end
            end
            S_FULL: begin
                if (!id_stop) begin
                    skid_unload_s = 1'b1;
                    id_pc_d       = skid_pc_s;
                    id_pc4_d      = skid_pc_s + 32'd4;
                    id_instr_d    = skid_valid_s ? skid_instr_s : NONE;
                    state_d       = S_REQ;
                    if (resolve_s) begin
                        fetch_pc_d = target_s;
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, IF/ID and registered iram handshake outputs.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= PC_RESET;
            pend_q      <= 1'b0;
            pend_tgt_q  <= 32'h0000_0000;
            id_pc_q     <= 32'h0000_0000;
            id_pc4_q    <= 32'h0000_0000;
            id_instr_q  <= NONE;
            iram_req_q  <= 1'b0;
            iram_addr_q <= PC_RESET;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_instr_q  <= id_instr_d;
            iram_req_q  <= (state_d == S_REQ);
            iram_addr_q <= fetch_pc_d;
        end
    end

    if_skid_buf u_skid (
        .clk_i    (cpu_clk),
        .rst_n_i  (cpu_rst_n),
        .load_i   (skid_load_s),
        .unload_i (skid_unload_s),
        .pc_i     (fetch_pc_q),
        .instr_i  (iram_rdata),
        .valid_o  (skid_valid_s),
        .pc_o     (skid_pc_s),
        .instr_o  (skid_instr_s)
    );

    assign iram_req   = iram_req_q;
    assign iram_addr  = iram_addr_q;
    assign if_o_pc    = id_pc_q;
    assign if_o_pc_4  = id_pc4_q;
    assign if_o_instr = id_instr_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for stage_if: sequential fetch, redirects,
// stalls through the skid buffer, slow memory and mid-request reset.
module tb_stage_if;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        id_stop;
    logic [2:0]  jsel;
    logic [31:0] branch_addr, j_addr, jc_addr;
    logic        iram_req;
    logic [31:0] iram_addr;
    logic        iram_ack;
    logic [31:0] iram_rdata;
    logic [31:0] if_o_pc, if_o_pc_4, if_o_instr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign iram_rdata = word_at(iram_addr);

    stage_if #(.PC_RESET(32'hBFC0_0000)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst_n   (cpu_rst_n),
        .id_stop     (id_stop),
        .jsel        (jsel),
        .branch_addr (branch_addr),
        .j_addr      (j_addr),
        .jc_addr     (jc_addr),
        .iram_req    (iram_req),
        .iram_addr   (iram_addr),
        .iram_ack    (iram_ack),
        .iram_rdata  (iram_rdata),
        .if_o_pc     (if_o_pc),
        .if_o_pc_4   (if_o_pc_4),
        .if_o_instr  (if_o_instr)
    );

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset;
        cpu_rst_n   = 1'b0;
        id_stop     = 1'b0;
        jsel        = 3'b000;
        iram_ack    = 1'b0;
        branch_addr = 32'h0;
        j_addr      = 32'h0;
        jc_addr     = 32'h0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        cpu_rst_n = 1'b0;
        id_stop = 1'b0; jsel = 3'b000; iram_ack = 1'b0;
        branch_addr = 32'h0; j_addr = 32'h0; jc_addr = 32'h0;
        tick();
        n_total++; if (iram_req !== 1'b0) $display("FAIL rst_req: got %b want 0", iram_req); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0000) $display("FAIL rst_addr: got %h want bfc00000", iram_addr); else n_pass++;
        n_total++; if (if_o_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", if_o_pc); else n_pass++;
        n_total++; if (if_o_pc_4 !== 32'h0) $display("FAIL rst_pc4: got %h want 0", if_o_pc_4); else n_pass++;
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", if_o_instr); else n_pass++;
        cpu_rst_n = 1'b1;
        iram_ack  = 1'b1;
        tick();
        n_total++; if (iram_req !== 1'b1) $display("FAIL first_req: got %b want 1", iram_req); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0000) $display("FAIL first_addr: got %h want bfc00000", iram_addr); else n_pass++;
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL idle_ack_ignored: got %h want 0", if_o_instr); else n_pass++;
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp;
        do_reset();
        iram_ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 32'hBFC0_0000 + 32'(4 * i);
            n_total++; if (if_o_pc !== exp) $display("FAIL zw_pc[%0d]: got %h want %h", i, if_o_pc, exp); else n_pass++;
            n_total++; if (if_o_pc_4 !== exp + 32'd4) $display("FAIL zw_pc4[%0d]: got %h want %h", i, if_o_pc_4, exp + 32'd4); else n_pass++;
            n_total++; if (if_o_instr !== word_at(exp)) $display("FAIL zw_instr[%0d]: got %h want %h", i, if_o_instr, word_at(exp)); else n_pass++;
        end
    endtask

    task automatic test_branch;
        jsel = 3'b001; branch_addr = 32'hBFC0_0100;
        tick();
        jsel = 3'b000;
        n_total++; if (if_o_pc !== 32'hBFC0_000C) $display("FAIL br_delay_pc: got %h want bfc0000c", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0100) $display("FAIL br_fetch: got %h want bfc00100", iram_addr); else n_pass++;
        tick();
        n_total++; if (if_o_pc !== 32'hBFC0_0100) $display("FAIL br_target_pc: got %h want bfc00100", if_o_pc); else n_pass++;
        n_total++; if (if_o_instr !== word_at(32'hBFC0_0100)) $display("FAIL br_target_instr: got %h want %h", if_o_instr, word_at(32'hBFC0_0100)); else n_pass++;
    endtask

    task automatic test_priority;
        branch_addr = 32'h0000_2000; jc_addr = 32'h0000_3000; j_addr = 32'hFFFF_FFFC;
        jsel = 3'b111;
        tick();
        jsel = 3'b000;
        n_total++; if (iram_addr !== 32'h0000_2000) $display("FAIL prio_branch: got %h want 00002000", iram_addr); else n_pass++;
        tick();
        jsel = 3'b110;
        tick();
        jsel = 3'b000;
        n_total++; if (iram_addr !== 32'h0000_3000) $display("FAIL prio_jc: got %h want 00003000", iram_addr); else n_pass++;
        tick();
        n_total++; if (if_o_pc !== 32'h0000_3000) $display("FAIL prio_jc_pc: got %h want 00003000", if_o_pc); else n_pass++;
        jsel = 3'b100;
        tick();
        jsel = 3'b000;
        n_total++; if (iram_addr !== 32'hFFFF_FFFC) $display("FAIL j_fetch: got %h want fffffffc", iram_addr); else n_pass++;
        tick();
        n_total++; if (if_o_pc_4 !== 32'h0000_0000) $display("FAIL wrap_pc4: got %h want 00000000", if_o_pc_4); else n_pass++;
        n_total++; if (iram_addr !== 32'h0000_0000) $display("FAIL wrap_fetch: got %h want 00000000", iram_addr); else n_pass++;
    endtask

    task automatic test_stall;
        logic [31:0] exp;
        do_reset();
        iram_ack = 1'b1;
        tick();
        tick();
        id_stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (if_o_pc !== 32'hBFC0_0000) $display("FAIL stall_hold[%0d]: got %h want bfc00000", k, if_o_pc); else n_pass++;
            n_total++; if (iram_req !== 1'b0) $display("FAIL stall_noreq[%0d]: got %b want 0", k, iram_req); else n_pass++;
        end
        id_stop = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            exp = 32'hBFC0_0000 + 32'(4 * k);
            n_total++; if (if_o_pc !== exp) $display("FAIL stall_resume[%0d]: got %h want %h", k, if_o_pc, exp); else n_pass++;
            n_total++; if (if_o_instr !== word_at(exp)) $display("FAIL stall_instr[%0d]: got %h want %h", k, if_o_instr, word_at(exp)); else n_pass++;
        end
    endtask

    task automatic test_redirect_full;
        do_reset();
        iram_ack = 1'b1;
        tick();
        tick();
        id_stop = 1'b1;
        tick();
        id_stop = 1'b0; jsel = 3'b010; jc_addr = 32'h0000_0040;
        tick();
        jsel = 3'b000;
        n_total++; if (if_o_pc !== 32'hBFC0_0004) $display("FAIL full_delay_pc: got %h want bfc00004", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'h0000_0040) $display("FAIL full_target: got %h want 00000040", iram_addr); else n_pass++;
        n_total++; if (iram_req !== 1'b1) $display("FAIL full_req: got %b want 1", iram_req); else n_pass++;
        tick();
        n_total++; if (if_o_pc !== 32'h0000_0040) $display("FAIL full_target_pc: got %h want 00000040", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'h0000_0044) $display("FAIL full_next: got %h want 00000044", iram_addr); else n_pass++;
    endtask

    task automatic test_latency;
        do_reset();
        tick();
        tick();
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL lat_bubble0: got %h want 0", if_o_instr); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0000) $display("FAIL lat_stable0: got %h want bfc00000", iram_addr); else n_pass++;
        iram_ack = 1'b1;
        tick();
        n_total++; if (if_o_pc !== 32'hBFC0_0000) $display("FAIL lat_pc0: got %h want bfc00000", if_o_pc); else n_pass++;
        iram_ack = 1'b0; jsel = 3'b100; j_addr = 32'h0000_1000;
        tick();
        jsel = 3'b000;
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL lat_bubble1: got %h want 0", if_o_instr); else n_pass++;
        n_total++; if (if_o_pc !== 32'hBFC0_0000) $display("FAIL lat_bubble_pc: got %h want bfc00000", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0004) $display("FAIL lat_stable1: got %h want bfc00004", iram_addr); else n_pass++;
        iram_ack = 1'b1;
        tick();
        n_total++; if (if_o_pc !== 32'hBFC0_0004) $display("FAIL lat_delay_pc: got %h want bfc00004", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'h0000_1000) $display("FAIL lat_pend_apply: got %h want 00001000", iram_addr); else n_pass++;
        iram_ack = 1'b0;
        tick();
        iram_ack = 1'b1;
        tick();
        n_total++; if (if_o_pc !== 32'h0000_1000) $display("FAIL lat_target_pc: got %h want 00001000", if_o_pc); else n_pass++;
        n_total++; if (iram_addr !== 32'h0000_1004) $display("FAIL lat_pend_once: got %h want 00001004", iram_addr); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        iram_ack = 1'b1;
        repeat (3) tick();
        #2;
        cpu_rst_n = 1'b0;
        #1;
        n_total++; if (iram_req !== 1'b0) $display("FAIL arst_req: got %b want 0", iram_req); else n_pass++;
        n_total++; if (iram_addr !== 32'hBFC0_0000) $display("FAIL arst_addr: got %h want bfc00000", iram_addr); else n_pass++;
        n_total++; if (if_o_pc !== 32'h0) $display("FAIL arst_pc: got %h want 0", if_o_pc); else n_pass++;
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL arst_instr: got %h want 0", if_o_instr); else n_pass++;
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        tick();
        n_total++; if (iram_addr !== 32'hBFC0_0000) $display("FAIL arst_refetch: got %h want bfc00000", iram_addr); else n_pass++;
        n_total++; if (if_o_instr !== 32'h0) $display("FAIL arst_late_ack: got %h want 0", if_o_instr); else n_pass++;
        tick();
        n_total++; if (if_o_pc !== 32'hBFC0_0000) $display("FAIL arst_first_pc: got %h want bfc00000", if_o_pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_branch();
        test_priority();
        test_stall();
        test_redirect_full();
        test_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter: PC_RESET, 32'hBFC0_0000, first fetch address after reset.
REQ-002 cpu_clk  in  1  single clock; all state on rising edge.
REQ-003 cpu_rst_n  in  1  reset; asynchronous, active-low.
REQ-004 id_stop  in  1  ID load-use stall; IF/ID register holds.
REQ-005 jsel  in  3  one-hot redirect from ID: [0] branch, [1] register jump, [2] absolute jump; 0 = sequential.
REQ-006 branch_addr, j_addr, jc_addr  in  32 each  targets selected by jsel[0], jsel[2] and jsel[1] respectively.
REQ-007 iram_req  out  1  fetch request, asserted while a request is outstanding.
REQ-008 iram_addr  out  32  fetch address; stable while iram_req=1.
REQ-009 iram_ack  in  1  word valid this cycle; ignored when iram_req=0.
REQ-010 iram_rdata  in  32  fetched instruction.
REQ-011 if_o_pc, if_o_pc_4, if_o_instr  out  32 each  IF/ID register contents feeding ID (pc, pc+4, instruction).

Function
REQ-012 FSM states: S_IDLE (no request), S_REQ (iram_req=1, iram_addr=fetch_pc), S_FULL (skid buffer holds one word, no request).
REQ-013 S_IDLE -> S_REQ one cycle after reset deassertion, unconditionally.
REQ-014 S_REQ, iram_ack=1, id_stop=0: word, fetch_pc and fetch_pc+4 load into IF/ID; stay S_REQ; fetch_pc updates per REQ-019.
REQ-015 S_REQ, iram_ack=1, id_stop=1: word and PC load into skid buffer; go S_FULL; IF/ID holds.
REQ-016 S_REQ, iram_ack=0, id_stop=0: IF/ID loads bubble (instr NONE = 32'h0, pc/pc_4 unchanged); stay S_REQ.
REQ-017 S_FULL, id_stop=0: skid buffer moves into IF/ID; go S_REQ. S_FULL, id_stop=1: hold everything.
REQ-018 id_stop=1 in any state: IF/ID holds all three fields.
REQ-019 Redirect resolves in a cycle with id_stop=0, jsel!=0 and if_o_instr!=NONE; target = jsel-selected address. Priority if several bits are set: jsel[0] > jsel[1] > jsel[2].
REQ-020 Delay slot preserved: the word fetched after the jump is always delivered to ID; the fetch after it uses the target.
REQ-021 fetch_pc update on iram_ack acceptance: target if a redirect is pending or resolves in the same cycle; otherwise fetch_pc+4.
REQ-022 Redirect resolving while the delay slot is in the skid buffer (S_FULL, fetch_pc already advanced, no request yet): fetch_pc <= target directly.
REQ-023 Pending redirect flag sets on resolution, clears on the cycle it is applied, and is never applied twice.
REQ-024 Addresses wrap modulo 2^32; no alignment check.
REQ-025 Fetch-to-ID latency is one cycle after the iram_ack edge when unstalled; sustained throughput is 1 instruction/cycle with zero-wait memory.

Reset
REQ-026 Asynchronous assertion of cpu_rst_n=0 forces: state S_IDLE, fetch_pc=PC_RESET, iram_req=0, iram_addr=PC_RESET, if_o_pc=0, if_o_pc_4=0, if_o_instr=NONE, skid buffer empty, pending redirect cleared.
REQ-027 Reset mid-request abandons the outstanding fetch; a late iram_ack in S_IDLE is ignored.

Structure
REQ-028 instr_addr, instr_data, NONE, RESET and the FSM state enum live in mips_abb_pkg.
REQ-029 The skid buffer (one-entry pc/instr holding register with valid flag) is sub-module if_skid_buf; all other logic is flat.

Verification
REQ-030 Zero-wait iram (ack every request cycle): after reset, ID sees pc BFC00000, BFC00004, BFC00008 on consecutive cycles.
REQ-031 Branch at BFC00008 with jsel=3'b001, branch_addr=BFC00100: ID sees BFC0000C (delay slot), then BFC00100.
REQ-032 id_stop=1 for 3 cycles while ack arrives: word goes to skid buffer; no word is lost or duplicated; the sequence resumes in order.
REQ-033 Redirect resolving while the delay slot sits in S_FULL (jc_addr=00000040): the next iram_addr is 00000040.
REQ-034 iram ack latency of 2 cycles: ID receives one NONE bubble between instructions; iram_addr stays stable until ack.
REQ-035 cpu_rst_n pulsed low mid-request: outputs return to reset values asynchronously; the next fetch is PC_RESET.
